// File: rtl/uart_frame_buffer_if.sv
// Byte-in / frame-out bus of the UART frame buffer.
// master: UART receiver plus control-logic reader; slave: the frame buffer.
interface uart_frame_buffer_if #(
   parameter int OVR_W = 8
);
   logic [7:0]       rx_data;
   logic             rx_wr_n;
   logic [6:0]       rd_addr;
   logic             rd_done;
   logic [7:0]       rd_data;
   logic             frame_ready;
   logic             frame_err;
   logic [6:0]       byte_cnt;
   logic [OVR_W-1:0] overrun_cnt;
   logic             busy;

   modport master (
      output rx_data, rx_wr_n, rd_addr, rd_done,
      input  rd_data, frame_ready, frame_err, byte_cnt, overrun_cnt, busy
   );

   modport slave (
      input  rx_data, rx_wr_n, rd_addr, rd_done,
      output rd_data, frame_ready, frame_err, byte_cnt, overrun_cnt, busy
   );
endinterface

// File: rtl/uart_frame_buffer.sv
// UART frame buffer: collects FRAME_LEN received bytes (last one is a
// mod-256 checksum of the others), verifies the checksum and holds the frame
// for random-access reading until the reader signals rd_done.
module uart_frame_buffer #(
   parameter int FRAME_LEN   = 113,
   parameter int GAP_TIMEOUT = 100000,
   parameter int OVR_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
   uart_frame_buffer_if.slave  bus
);

   localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
   localparam logic [6:0] LAST_IDX = 7'(FRAME_LEN - 1);
   localparam logic [6:0] FULL_CNT = 7'(FRAME_LEN);

   typedef enum logic [1:0] {IDLE, RECV, READY} state_t;

   state_t            state_q, state_d;
   logic              sync1_q, sync2_q, edge_q, byte_stb_q;
   logic [6:0]        byte_cnt_q, byte_cnt_d;
   logic [7:0]        sum_q, sum_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              err_q, err_d;
   logic [OVR_W-1:0]  ovr_q, ovr_d;
   logic              mem_we;
   logic [7:0]        rd_data_q;
   // Sized to the full 7-bit address space so any rd_addr/byte_cnt index is
   // in range; entries at FRAME_LEN and above are never written.
   logic [7:0]        mem_q [0:127];

   // Strobe comes from the UART bit-clock domain: two flops, then a
   // falling-edge detect so a held-low strobe yields exactly one pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         edge_q     <= 1'b1;
         byte_stb_q <= 1'b0;
      end else begin
         sync1_q    <= bus.rx_wr_n;
         sync2_q    <= sync1_q;
         edge_q     <= sync2_q;
         byte_stb_q <= edge_q & ~sync2_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         byte_cnt_q <= '0;
         sum_q      <= '0;
         gap_q      <= '0;
         err_q      <= 1'b0;
         ovr_q      <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         sum_q      <= sum_d;
         gap_q      <= gap_d;
         err_q      <= err_d;
         ovr_q      <= ovr_d;
      end
   end

   // Next-state logic: assemble, verify, hold, release.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      sum_d      = sum_q;
      gap_d      = gap_q;
      err_d      = 1'b0;
      ovr_d      = ovr_q;
      mem_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (byte_stb_q) begin
               mem_we     = 1'b1;
               sum_d      = bus.rx_data;
               byte_cnt_d = 7'd1;
               gap_d      = '0;
               state_d    = RECV;
            end
         end
         RECV: begin
            gap_d = gap_q + GAP_W'(1);
            if (byte_stb_q) begin
               gap_d  = '0;
               mem_we = 1'b1;
               if (byte_cnt_q == LAST_IDX) begin
                  if (bus.rx_data == sum_q) begin
                     byte_cnt_d = FULL_CNT;
                     state_d    = READY;
                  end else begin
                     err_d      = 1'b1;
                     byte_cnt_d = '0;
                     state_d    = IDLE;
                  end
               end else begin
                  sum_d      = sum_q + bus.rx_data;
                  byte_cnt_d = byte_cnt_q + 7'd1;
               end
            end else if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
               // Sender stalled mid-frame: drop the partial frame.
               err_d      = 1'b1;
               byte_cnt_d = '0;
               gap_d      = '0;
               state_d    = IDLE;
            end
         end
         READY: begin
            // Buffer is owned by the reader; incoming bytes are only counted.
            if (byte_stb_q && (ovr_q != '1)) ovr_d = ovr_q + OVR_W'(1);
            if (bus.rd_done) begin
               byte_cnt_d = '0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) mem_q[byte_cnt_q] <= bus.rx_data;
   end

   // Registered read port; indices past the frame read as zero.
   always_ff @(posedge clk) begin
      if (rst)                                   rd_data_q <= '0;
      else if ({1'b0, bus.rd_addr} < 8'(FRAME_LEN)) rd_data_q <= mem_q[bus.rd_addr];
      else                                       rd_data_q <= '0;
   end

   assign bus.rd_data     = rd_data_q;
   assign bus.frame_ready = (state_q == READY);
   assign bus.frame_err   = err_q;
   assign bus.byte_cnt    = byte_cnt_q;
   assign bus.overrun_cnt = ovr_q;
   assign bus.busy        = (state_q == RECV);

endmodule
